// File: rtl/jt9346_pkg.sv
// jt9346_pkg: shared encodings for the 93C46 serial master.
// Command ops, EEPROM opcodes, frame sizes and controller states.
package jt9346_pkg;

    typedef enum logic [2:0] {
        OP_READ  = 3'd0,
        OP_WRITE = 3'd1,
        OP_ERASE = 3'd2,
        OP_EWEN  = 3'd3,
        OP_EWDS  = 3'd4,
        OP_ERAL  = 3'd5,
        OP_WRAL  = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    localparam logic [1:0] EE_READ  = 2'b10;
    localparam logic [1:0] EE_WRITE = 2'b01;
    localparam logic [1:0] EE_ERASE = 2'b11;
    localparam logic [1:0] EE_EXT   = 2'b00;

    localparam logic [3:0] EXT_EWEN = {EE_EXT, 2'b11};
    localparam logic [3:0] EXT_EWDS = {EE_EXT, 2'b00};
    localparam logic [3:0] EXT_ERAL = {EE_EXT, 2'b10};
    localparam logic [3:0] EXT_WRAL = {EE_EXT, 2'b01};

    localparam int FRAME_LEN = 9;
    localparam int DATA_LEN  = 16;

    typedef enum logic [3:0] {
        S_INIT,
        S_IDLE,
        S_SEL,
        S_CMD,
        S_WR,
        S_RD,
        S_DESEL,
        S_POLL,
        S_DONE
    } state_e;

    function automatic logic [8:0] frame(op_e op, logic [5:0] addr);
        case (op)
            OP_READ:  frame = {1'b1, EE_READ, addr};
            OP_WRITE: frame = {1'b1, EE_WRITE, addr};
            OP_ERASE: frame = {1'b1, EE_ERASE, addr};
            OP_EWEN:  frame = {1'b1, EXT_EWEN, 4'b0000};
            OP_EWDS:  frame = {1'b1, EXT_EWDS, 4'b0000};
            OP_ERAL:  frame = {1'b1, EXT_ERAL, 4'b0000};
            OP_WRAL:  frame = {1'b1, EXT_WRAL, 4'b0000};
            default:  frame = '0;
        endcase
    endfunction

    // Programming ops leave the EEPROM busy and need a ready poll.
    function automatic logic needs_poll(op_e op);
        return op inside {OP_WRITE, OP_ERASE, OP_ERAL, OP_WRAL};
    endfunction

endpackage

// File: rtl/jt9346_sclk_gen.sv
// jt9346_sclk_gen: serial clock phase counter for the 93C46 master.
// Low phase first, then high phase, each SCLK_DIV clk cycles long.
module jt9346_sclk_gen
    import jt9346_pkg::*;
#(
    parameter int SCLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic sclk,
    output logic fall_stb,
    output logic rise_last_stb,
    output logic pulse_done
);

    localparam int CW = $clog2(SCLK_DIV);

    logic [CW-1:0] cnt;
    logic          high;
    logic          last;

    assign last = (cnt == CW'(SCLK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            high <= 1'b0;
        end else if (!run) begin
            cnt  <= '0;
            high <= 1'b0;
        end else if (last) begin
            cnt  <= '0;
            high <= ~high;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign sclk          = high;
    assign fall_stb      = run && !high && (cnt == '0);
    assign rise_last_stb = run && high && last;
    assign pulse_done    = rise_last_stb;

endmodule

// File: rtl/jt9346_master.sv
// jt9346_master: parallel command to 93C46 serial frame converter.
// Define JT9346_MASTER_TIMEOUT_EN to bound the ready poll by POLL_MAX clks.
module jt9346_master
    import jt9346_pkg::*;
#(
    parameter int SCLK_DIV = 4,
    parameter int CS_GAP   = 4,
    parameter int POLL_MAX = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [5:0]  cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        sclk,
    output logic        sdi,
    output logic        scs,
    input  logic        sdo
);

    localparam int CMAX = (POLL_MAX > CS_GAP) ? POLL_MAX : CS_GAP;
    localparam int CW   = $clog2(CMAX + 1);

    state_e        state, state_n;
    op_e           op;
    logic [5:0]    addr;
    logic [15:0]   wdata;
    logic [15:0]   shreg;
    logic [15:0]   rdata;
    logic [4:0]    bcnt;
    logic [CW-1:0] cnt;
    logic          err;

    logic run, fall_stb, rise_last_stb, pulse_done;
    logic cmd_last, data_last, poll_ok, poll_tmo;

    jt9346_sclk_gen #(
        .SCLK_DIV(SCLK_DIV)
    ) u_sclk (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .sclk         (sclk),
        .fall_stb     (fall_stb),
        .rise_last_stb(rise_last_stb),
        .pulse_done   (pulse_done)
    );

    assign cmd_last  = (state == S_CMD) && pulse_done
                     && (bcnt == 5'(FRAME_LEN - 1));
    assign data_last = (state == S_WR || state == S_RD) && pulse_done
                     && (bcnt == 5'(DATA_LEN - 1));

    // First two poll clks cover the EEPROM input synchroniser.
    assign poll_ok = (cnt >= CW'(2)) && sdo;

    always_comb begin
        state_n  = state;
        run      = 1'b0;
        poll_tmo = 1'b0;
`ifdef JT9346_MASTER_TIMEOUT_EN
        poll_tmo = !poll_ok && (cnt == CW'(POLL_MAX - 1));
`endif
        unique case (state)
            S_INIT: state_n = S_IDLE;
            S_IDLE: begin
                if (cmd_valid)
                    state_n = (cmd_op == OP_RSVD) ? S_DONE : S_SEL;
            end
            S_SEL: state_n = S_CMD;
            S_CMD: begin
                run = 1'b1;
                if (cmd_last) begin
                    if (op == OP_READ)
                        state_n = S_RD;
                    else if (op == OP_WRITE || op == OP_WRAL)
                        state_n = S_WR;
                    else
                        state_n = S_DESEL;
                end
            end
            S_WR, S_RD: begin
                run = 1'b1;
                if (data_last)
                    state_n = S_DESEL;
            end
            S_DESEL: begin
                if (cnt == CW'(CS_GAP - 1))
                    state_n = needs_poll(op) ? S_POLL : S_DONE;
            end
            S_POLL: begin
                if (poll_ok || poll_tmo)
                    state_n = S_DONE;
            end
            S_DONE: state_n = S_IDLE;
            default: state_n = S_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_INIT;
            op    <= OP_READ;
            addr  <= '0;
            wdata <= '0;
            shreg <= '0;
            rdata <= '0;
            bcnt  <= '0;
            cnt   <= '0;
            err   <= 1'b0;
            sdi   <= 1'b0;
        end else begin
            state <= state_n;
            if (state_n != state)
                cnt <= '0;
            else if (!(&cnt))
                cnt <= cnt + CW'(1);

            if (state == S_IDLE && cmd_valid) begin
                op    <= op_e'(cmd_op);
                addr  <= cmd_addr;
                wdata <= cmd_wdata;
                err   <= (cmd_op == OP_RSVD);
            end

            if (state == S_SEL) begin
                shreg <= {frame(op, addr), 7'b0};
                bcnt  <= '0;
            end

            if (pulse_done)
                bcnt <= (cmd_last || data_last) ? 5'd0 : bcnt + 5'd1;

            if (fall_stb) begin
                if (state == S_RD) begin
                    sdi <= 1'b0;
                end else begin
                    sdi   <= shreg[15];
                    shreg <= {shreg[14:0], 1'b0};
                end
            end

            if (state == S_RD && rise_last_stb)
                shreg <= {shreg[14:0], sdo};

            if (cmd_last && (op == OP_WRITE || op == OP_WRAL))
                shreg <= wdata;

            if (state == S_DESEL)
                sdi <= 1'b0;

            if (state == S_POLL && poll_tmo)
                err <= 1'b1;

            if (state == S_DESEL && state_n == S_DONE && op == OP_READ)
                rdata <= shreg;
        end
    end

    assign scs = (state == S_SEL) || (state == S_CMD) || (state == S_WR)
              || (state == S_RD) || (state == S_POLL);
    assign cmd_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_DONE);
    assign rsp_err   = rsp_valid && err;
    assign rsp_rdata = rdata;

endmodule

// File: doc/jt9346_master.md
Name: jt9346_master

Overview:
- Host-side serial master for the 93C46-compatible EEPROM model; sits directly upstream of it and drives its sclk/sdi/scs pins, sampling its sdo.
- Converts one parallel command per handshake (read/write/erase/EWEN/EWDS/ERAL/WRAL) into the serial bit sequence.
- Returns read data, and waits for ready after programming operations.
- Used by the NVRAM save/load path and by the CPU-side EEPROM latch when running in cooked-command mode.

Parameters:
- SCLK_DIV, 4, clk cycles per sclk half-period; legal values are ≥ 4.
- CS_GAP, 4, clk cycles with scs low between the command and the busy poll.
- POLL_MAX, 1024, clk cycles allowed for the busy poll before a timeout (used only with the timeout feature).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  master idle; command accepted when valid&&ready
- cmd_op  in  3  0 READ, 1 WRITE, 2 ERASE, 3 EWEN, 4 EWDS, 5 ERAL, 6 WRAL, 7 reserved
- cmd_addr  in  6  word address
- cmd_wdata  in  16  write data for WRITE/WRAL
- rsp_valid  out  1  one-cycle pulse at command completion
- rsp_rdata  out  16  READ result; holds its value until the next READ completes
- rsp_err  out  1  qualified by rsp_valid; reserved op or poll timeout
- sclk  out  1  serial clock to EEPROM
- sdi  out  1  serial data to EEPROM
- scs  out  1  chip select to EEPROM, active high
- sdo  in  1  serial data / ready from EEPROM

Behaviour:
- Reset values: sclk=0, sdi=0, scs=0, cmd_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=16'h0000.
- cmd_ready rises one cycle after rst is released.
- Reset asserted mid-operation aborts immediately; scs drops asynchronously. The EEPROM returns to idle on scs low.
- Command accept: on valid&&ready, latch op/addr/wdata and drop cmd_ready.
- Reserved op: rsp_valid=1 with rsp_err=1 on the next cycle; no pin activity.
- Frame (9 bits, MSB first): start 1, op[1:0], addr[5:0].
  - READ: 10+addr. WRITE: 01+addr. ERASE: 11+addr.
  - EWEN: 00 11 0000. EWDS: 00 00 0000. ERAL: 00 10 0000. WRAL: 00 01 0000.
- Bit timing:
  - sdi changes only while sclk is low, at the start of the low phase.
  - sclk is low for SCLK_DIV cycles, then high for SCLK_DIV cycles.
  - scs rises at least SCLK_DIV cycles before the first sclk rise.
- FSM states: IDLE -> SEL -> SH_CMD(9 pulses) -> {SH_WR(16 pulses) | SH_RD(16 pulses) | DESEL} -> DESEL -> {POLL | DONE} -> DONE -> IDLE.
  - SH_WR is taken by WRITE and WRAL, sending wdata MSB first.
  - SH_RD is taken by READ; sdi is held at 0.
  - SH_RD sampling: sdo is sampled on the last clk of each high phase, shifting into the LSB. The first sample is data bit 15. No dummy pulse is issued; the dummy 0 appears before the first pulse.
  - After the last pulse, sclk returns low and scs drops.
  - DESEL holds scs low for CS_GAP cycles.
  - POLL is taken by WRITE/ERASE/ERAL/WRAL. In POLL, scs=1 and sclk=0, and sdo is sampled every clk. sdo=1 -> DONE. The master waits two clks after scs rises before the first sample, to cover the EEPROM input sync.
  - READ/EWEN/EWDS go DESEL -> DONE with no poll.
- DONE: rsp_valid=1 for one cycle; scs=0.
  - rsp_rdata updates on READ only.
  - cmd_ready=1 on the following cycle.
- Back-to-back commands: minimum CS_GAP cycles with scs low between frames, guaranteed by DESEL.
- cmd_valid while busy: ignored; cmd_ready=0 throughout.

Optional Feature:
- Macro: JT9346_MASTER_TIMEOUT_EN.
- Defined: POLL counts clks. On reaching POLL_MAX with sdo still 0, drop scs and finish with rsp_valid=1, rsp_err=1.
- Undefined: POLL waits indefinitely, POLL_MAX is unused, and rsp_err is set only for the reserved op.

Decomposition:
- Shared package jt9346_pkg:
  - cmd_op encodings (OP_READ..OP_WRAL, OP_RSVD).
  - 2-bit EEPROM opcodes and 4-bit extended-op prefixes (EWEN=11, EWDS=00, ERAL=10, WRAL=01).
  - Frame length 9 and data length 16.
- Sub-module jt9346_sclk_gen: SCLK_DIV phase counter.
  - Inputs: run (sclk runs while asserted).
  - Outputs: sclk, fall_stb (drive sdi), rise_last_stb (sample sdo), pulse_done.
  - The FSM counts pulses using its strobes.

Test Plan:
- EEPROM model word 0 = 16'h000c; READ addr 0 -> after 25 sclk pulses, rsp_valid with rsp_rdata=16'h000c and rsp_err=0; sdi frame observed as 1,1,0,000000.
- EWEN, then WRITE addr 5 data 16'hA5C3, then READ addr 5 -> rsp_rdata=16'hA5C3; WRITE response arrives only after a POLL with sdo=1.
- EWEN, then ERAL, then READ addr 1 -> 16'hffff; the POLL phase must last at least 64 clks while the model is busy.
- WRAL data 16'h1234, then READ addr 63 and addr 0 -> both 16'h1234.
- cmd_op=7 -> rsp_valid and rsp_err on the next cycle; scs/sclk stay 0.
- With JT9346_MASTER_TIMEOUT_EN, POLL_MAX=32 and sdo forced 0 during POLL -> rsp_err=1 at poll cycle 32 and scs=0. Asserting rst mid-SH_CMD -> scs=0 immediately and cmd_ready=1 one cycle after release.
